// File: rtl/sumador_pkg.sv
// Shared definitions for the saturating accumulator family: FSM encoding and default sizes.
package sumador_pkg;

    localparam int N_DEF     = 24;
    localparam int TERMS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACUM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sumador_sat_add.sv
// Combinational 2N-bit signed add that clamps to the representable range and flags the clamp.
module sumador_sat_add
    import sumador_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    output logic [2*N-1:0] sum,
    output logic           sat
);

    localparam logic [2*N-1:0] SAT_MAX = {1'b0, {(2*N-1){1'b1}}};
    localparam logic [2*N-1:0] SAT_MIN = {1'b1, {(2*N-1){1'b0}}};

    logic [2*N:0] wide;

    assign wide = {a[2*N-1], a} + {b[2*N-1], b};

    // Overflow shows as disagreement between the extra sign bit and the 2N-bit sign bit.
    always_comb begin
        sat = wide[2*N] ^ wide[2*N-1];
        sum = wide[2*N-1:0];
        if (sat) begin
            sum = wide[2*N] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/sumador_acumulador_sat.sv
// Sequential saturating accumulator: offset load on start, TERMS products over valid/ready.
// Optional sticky overflow flag enabled by defining SUMADOR_OVF_FLAG_EN.
module sumador_acumulador_sat
    import sumador_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int TERMS = TERMS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] Sum_ext,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] Multiplica,
    output logic [2*N-1:0] Suma_G,
    output logic           out_valid,
    output logic           ovf,
    output logic [1:0]     state_dbg
);

    localparam int CW = $clog2(TERMS + 1);
    localparam logic [CW-1:0] LAST = CW'(TERMS - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] add_sum;
    logic           add_sat;
    logic           accept;
    logic           last_accept;

    sumador_sat_add #(.N(N)) u_sat_add (
        .a   (acc),
        .b   (Multiplica),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Handshake: a product transfers on a rising edge where in_valid && in_ready, with
    // in_ready high only in ACUM; a start in the same cycle takes priority and drops it.
    assign in_ready    = (state == ACUM);
    assign accept      = in_valid && in_ready && !start;
    assign last_accept = accept && (cnt == LAST);
    assign out_valid   = (state == DONE);
    assign state_dbg   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACUM;
            ACUM:    if (last_accept) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            Suma_G <= '0;
        end else begin
            state <= state_nxt;
            if (start && state != DONE) begin
                acc <= Sum_ext;
                cnt <= '0;
            end else if (accept) begin
                acc <= add_sum;
                cnt <= cnt + CW'(1);
            end
            // Result is captured with the final add so it is valid while out_valid is high.
            if (last_accept) begin
                Suma_G <= add_sum;
            end
        end
    end

`ifdef SUMADOR_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (start && state != DONE) begin
            ovf_q <= 1'b0;
        end else if (accept && add_sat) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_add_sat;
    assign unused_add_sat = add_sat;
    assign ovf            = 1'b0;
`endif

endmodule
